// File: rtl/rr_reg_arbiter_if.sv
// Handshake bundle between N_REQ write requesters and the shared-register arbiter.
// Requesters drive the master side and the arbiter drives the slave side.
interface rr_reg_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wr_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       reg_q;
  logic                    busy;

  modport master (output req, wr_data, input gnt, done, reg_q, busy);
  modport slave  (input req, wr_data, output gnt, done, reg_q, busy);
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin owner of one shared register: grant -> load -> hold HOLD_CYCLES -> done pulse.
// One grant per HOLD_CYCLES+3 cycles; requests arriving while busy wait and are never preempted.
module rr_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  rr_reg_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic             found;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First pending requester strictly after the last winner, wrapping around.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDX_W'(N_REQ - 1);
      winner   <= '0;
      cnt      <= '0;
      bus.gnt  <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
      bus.reg_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            winner   <= pick;
            last     <= pick;
            bus.gnt  <= onehot(pick);
            bus.busy <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req[winner]) begin
            bus.reg_q <= bus.wr_data[int'(winner)*DATA_W +: DATA_W];
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            state     <= HOLD;
          end else begin
            // Requester withdrew: drop the grant, keep the pointer advanced.
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus.gnt  <= '0;
            bus.done <= onehot(winner);
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          bus.done <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: transaction-timeline model checked every cycle plus directed literal checks.
module tb_rr_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rr_reg_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  rr_reg_arbiter #(.N_REQ(N), .DATA_W(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline starting at its grant edge m_t;
  // outputs follow from the offset of the current edge within that timeline.
  int            e;
  int            m_last;
  int            m_w;
  int            m_t;
  bit            m_act;
  logic [W-1:0]  m_reg;

  function automatic int rr_pick(input int lst, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    bit was;
    int off;
    if (rst) begin
      m_act  = 0;
      m_last = N - 1;
      m_reg  = '0;
    end else begin
      was = m_act;
      if (m_act) begin
        off = e - m_t;
        if (off == 1) begin
          if (bus.req[m_w]) m_reg = bus.wr_data[m_w*W +: W];
          else m_act = 0;
        end else if (off == H + 2) begin
          m_act = 0;
        end
      end
      if (!was && (|bus.req)) begin
        m_w    = rr_pick(m_last, bus.req);
        m_last = m_w;
        m_t    = e;
        m_act  = 1;
      end
    end
  endtask

  initial begin
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    int off;
    e = 0;
    m_act = 0;
    m_last = N - 1;
    m_reg = '0;
    forever begin
      @(posedge clk);
      e++;
      model_step();
      #1;
      off = e - m_t;
      eg = (m_act && off <= H) ? N'(1) << m_w : '0;
      ed = (m_act && off == H + 1) ? N'(1) << m_w : '0;
      chk("mdl_gnt", 32'(bus.gnt), 32'(eg));
      chk("mdl_done", 32'(bus.done), 32'(ed));
      chk("mdl_busy", 32'(bus.busy), 32'(m_act));
      chk("mdl_reg_q", 32'(bus.reg_q), 32'(m_reg));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [N-1:0] seq [8];
  int           at  [8];

  // Record the first n grant rising edges (bounded).
  task automatic rec(input int n);
    int got;
    logic [N-1:0] prev;
    got  = 0;
    prev = '0;
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      if (bus.gnt != '0 && prev == '0) begin
        seq[got] = bus.gnt;
        at[got]  = c;
        got++;
      end
      prev = bus.gnt;
    end
    chk("rec_count", 32'(got), 32'(n));
  endtask

  initial begin
    logic [N-1:0] exp3 [5];
    logic [N-1:0] exp4 [3];
    exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp4 = '{4'b0010, 4'b1000, 4'b0010};
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.wr_data = 32'hDEADBEEF;

    // 1: reset holds everything low despite requests
    repeat (3) begin
      tick();
      chk("t1_gnt", 32'(bus.gnt), 32'h0);
      chk("t1_done", 32'(bus.done), 32'h0);
      chk("t1_busy", 32'(bus.busy), 32'h0);
      chk("t1_reg_q", 32'(bus.reg_q), 32'h0);
    end
    bus.req = '0;
    rst = 1'b0;
    tick();

    // 2: single requester 2 with A5
    bus.req = 4'b0100;
    bus.wr_data = 32'h44A52211;
    tick();
    chk("t2_gnt1", 32'(bus.gnt), 32'h4);
    chk("t2_busy1", 32'(bus.busy), 32'h1);
    chk("t2_reg1", 32'(bus.reg_q), 32'h00);
    tick();
    chk("t2_gnt2", 32'(bus.gnt), 32'h4);
    chk("t2_reg2", 32'(bus.reg_q), 32'hA5);
    tick();
    chk("t2_gnt3", 32'(bus.gnt), 32'h4);
    chk("t2_done3", 32'(bus.done), 32'h0);
    tick();
    chk("t2_gnt4", 32'(bus.gnt), 32'h0);
    chk("t2_done4", 32'(bus.done), 32'h4);
    bus.req = '0;
    tick();
    chk("t2_done5", 32'(bus.done), 32'h0);
    chk("t2_busy5", 32'(bus.busy), 32'h0);
    chk("t2_reg5", 32'(bus.reg_q), 32'hA5);

    // 3: full rotation with all requesting
    do_reset();
    bus.req = 4'b1111;
    bus.wr_data = 32'h04030201;
    rec(5);
    for (int i = 0; i < 5; i++) chk("t3_seq", 32'(seq[i]), 32'(exp3[i]));
    for (int i = 0; i < 4; i++) chk("t3_space", 32'(at[i+1] - at[i]), 32'd5);
    bus.req = '0;
    repeat (8) tick();

    // 4: wrap and skip from pointer 3
    do_reset();
    bus.req = 4'b1010;
    rec(3);
    for (int i = 0; i < 3; i++) chk("t4_seq", 32'(seq[i]), 32'(exp4[i]));
    bus.req = '0;
    repeat (8) tick();

    // 5: abort in the GRANT cycle, pending requester 2 served next
    do_reset();
    bus.req = 4'b0001;
    bus.wr_data = 32'h00000011;
    repeat (4) tick();
    chk("t5_done0", 32'(bus.done), 32'h1);
    bus.req = '0;
    tick();
    bus.req = 4'b0110;
    bus.wr_data = 32'h00332211;
    tick();
    chk("t5_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    tick();
    chk("t5_abort_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_abort_reg", 32'(bus.reg_q), 32'h11);
    chk("t5_abort_done", 32'(bus.done), 32'h0);
    chk("t5_abort_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t5_gnt2", 32'(bus.gnt), 32'h4);
    repeat (2) tick();
    chk("t5_reg2", 32'(bus.reg_q), 32'h33);
    tick();
    chk("t5_done2", 32'(bus.done), 32'h4);
    bus.req = '0;
    repeat (3) tick();

    // 6: asynchronous reset during HOLD
    do_reset();
    bus.req = 4'b0001;
    bus.wr_data = 32'h00000055;
    repeat (2) tick();
    chk("t6_hold_gnt", 32'(bus.gnt), 32'h1);
    chk("t6_hold_reg", 32'(bus.reg_q), 32'h55);
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_rst_reg", 32'(bus.reg_q), 32'h0);
    chk("t6_rst_done", 32'(bus.done), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t6_rst_done2", 32'(bus.done), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0011;
    tick();
    chk("t6_regrant", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, errors=%0d", n_err);
    $fatal(1, "timeout");
  end
endmodule
